// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FAULT = 2'd3
    } state_e;

    // A fetch address is usable when word aligned and the whole word lies below limit.
    // One extra bit keeps pc+4 from wrapping back into range.
    function automatic logic pc_legal(input logic [PC_W:0] addr, input logic [PC_W:0] limit);
        return ((addr[1:0] & ALIGN_MASK) == 2'b00) && ((addr + (PC_W + 1)'(3)) < limit);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: pipeline control in, memory port, IF/ID output.
// Perf counter signals exist only when IMEM_FETCH_PERF_EN is defined.
interface imem_fetch_ctrl_if;
    import fetch_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic [PC_W-1:0]    if_pc_plus4;
    logic               fault;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_bubbles;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fault,
        output perf_fetched, perf_bubbles
    );
    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fault,
        input  perf_fetched, perf_bubbles
    );
`else
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fault
    );
    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fault
    );
`endif
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instruction hold register and the IF output mux.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               capture,
    input  logic               clear,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               rsp_valid,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr
);
    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr;

    // Latch the word on the memory bus when the pipeline stalls on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_instr <= '0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_instr <= imem_rdata;
        end
    end

    // Held word wins over the live memory data; zero when nothing is valid.
    always_comb begin
        if_valid = rsp_valid | hold_valid;
        if_instr = '0;
        if (hold_valid) begin
            if_instr = hold_instr;
        end else if (rsp_valid) begin
            if_instr = imem_rdata;
        end
    end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a synchronous-read instruction memory: owns the PC,
// tags returned words, absorbs stalls without refetch, applies redirects.
// Optional perf counters: define IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    imem_fetch_ctrl_if.master bus
);
    localparam int unsigned      PCX_W    = PC_W + 1;
    localparam logic [PCX_W-1:0] PC_LIMIT = PCX_W'(IMEM_BYTES);

    state_e             state;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    rsp_pc;
    logic               rsp_valid;
    logic               fault_q;
    logic               redir_ok;
    logic               adv_ok;
    logic               capture;
    logic               clear;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;

    // Legality of the next PC candidates and hold-buffer control.
    always_comb begin
        redir_ok = pc_legal({1'b0, bus.redirect_pc}, PC_LIMIT);
        adv_ok   = pc_legal({1'b0, fetch_pc} + PCX_W'(PC_STEP), PC_LIMIT);
        capture  = (state == RUN) && bus.stall && !bus.redirect_valid && rsp_valid;
        clear    = bus.redirect_valid || !bus.stall;
    end

    // Fetch FSM: redirect beats stall beats advance; faults freeze fetch_pc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            fetch_pc  <= RESET_PC;
            rsp_pc    <= '0;
            rsp_valid <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                FAULT: begin
                    if (bus.redirect_valid && redir_ok) begin
                        fetch_pc  <= bus.redirect_pc;
                        rsp_valid <= 1'b0;
                        fault_q   <= 1'b0;
                        state     <= RUN;
                    end else if (!bus.stall) begin
                        // Final word fetched before the fault drains once accepted.
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    if (bus.redirect_valid) begin
                        rsp_valid <= 1'b0;
                        if (redir_ok) begin
                            fetch_pc <= bus.redirect_pc;
                            state    <= RUN;
                        end else begin
                            fault_q <= 1'b1;
                            state   <= FAULT;
                        end
                    end else if (bus.stall && (state != BOOT)) begin
                        if (capture) begin
                            state <= STALL;
                        end
                    end else begin
                        rsp_pc    <= fetch_pc;
                        rsp_valid <= 1'b1;
                        if (adv_ok) begin
                            fetch_pc <= fetch_pc + PC_W'(PC_STEP);
                            state    <= RUN;
                        end else begin
                            fault_q <= 1'b1;
                            state   <= FAULT;
                        end
                    end
                end
            endcase
        end
    end

    fetch_hold_buf u_hold (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .clear      (clear),
        .imem_rdata (bus.imem_rdata),
        .rsp_valid  (rsp_valid),
        .if_valid   (if_valid),
        .if_instr   (if_instr)
    );

    assign bus.imem_addr   = fetch_pc;
    assign bus.if_valid    = if_valid;
    assign bus.if_instr    = if_instr;
    assign bus.if_pc       = rsp_pc;
    assign bus.if_pc_plus4 = rsp_pc + PC_W'(PC_STEP);
    assign bus.fault       = fault_q;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    // Saturating counts of delivered instructions and non-fault bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (if_valid && !bus.stall && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!if_valid && (state != FAULT) && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end

    assign bus.perf_fetched = perf_fetched;
    assign bus.perf_bubbles = perf_bubbles;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, async-reset sequence,
// then random stimulus against a PC-stream reference model.
module tb_imem_fetch_ctrl;
    localparam int unsigned IMEM_BYTES = 64;
    localparam int unsigned N_WORDS    = IMEM_BYTES / 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word view for the model, byte view for the memory itself.
    logic [31:0] words [N_WORDS];
    logic [7:0]  mem_b [IMEM_BYTES];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int idx;
        if (64'(a) + 64'd3 >= 64'(IMEM_BYTES)) return 32'hDEAD_BEEF;
        idx = int'(a);
        return {mem_b[idx + 3], mem_b[idx + 2], mem_b[idx + 1], mem_b[idx]};
    endfunction

    always @(posedge clk) bus.imem_rdata <= rd_word(bus.imem_addr);

    // Reference model: which PC is presented, which PC is fetched next, fault flag.
    logic        m_valid, m_fault, m_boot;
    logic [31:0] m_pc, m_next;
    logic [31:0] m_fetched, m_bubbles;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (64'(a) + 64'd3 < 64'(IMEM_BYTES));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1;
        m_pc = 32'h0; m_next = 32'h0;
        m_fetched = 32'h0; m_bubbles = 32'h0;
    endtask

    task automatic model_edge(input bit s, input bit rv, input logic [31:0] rpc);
        if (m_valid && !s && m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
        if (!m_valid && !m_fault && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 1;
        if (m_fault) begin
            if (rv && legal(rpc)) begin
                m_next = rpc; m_valid = 1'b0; m_fault = 1'b0;
            end else if (!s) begin
                m_valid = 1'b0;
            end
        end else if (rv) begin
            m_valid = 1'b0; m_boot = 1'b0;
            if (legal(rpc)) m_next = rpc;
            else            m_fault = 1'b1;
        end else if (!s || m_boot) begin
            m_pc = m_next; m_valid = 1'b1; m_boot = 1'b0;
            if (legal(m_next + 32'd4)) m_next = m_next + 32'd4;
            else                        m_fault = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] e_instr;
        e_instr = m_valid ? words[m_pc >> 2] : 32'h0;
        check({tag, " if_valid"}, 32'(bus.if_valid), 32'(m_valid));
        check({tag, " if_instr"}, bus.if_instr, e_instr);
        check({tag, " if_pc"}, bus.if_pc, m_pc);
        check({tag, " if_pc_plus4"}, bus.if_pc_plus4, m_pc + 32'd4);
        check({tag, " fault"}, 32'(bus.fault), 32'(m_fault));
        check({tag, " imem_addr"}, bus.imem_addr, m_next);
`ifdef IMEM_FETCH_PERF_EN
        check({tag, " perf_fetched"}, bus.perf_fetched, m_fetched);
        check({tag, " perf_bubbles"}, bus.perf_bubbles, m_bubbles);
`endif
    endtask

    task automatic cycle(input bit s, input bit rv, input logic [31:0] rpc);
        bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rpc;
        @(posedge clk);
        model_edge(s, rv, rpc);
        #1;
        compare_model("model");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " if_valid"}, 32'(bus.if_valid), 32'h0);
        check({tag, " if_instr"}, bus.if_instr, 32'h0);
        check({tag, " if_pc"}, bus.if_pc, 32'h0);
        check({tag, " fault"}, 32'(bus.fault), 32'h0);
        check({tag, " imem_addr"}, bus.imem_addr, 32'h0);
`ifdef IMEM_FETCH_PERF_EN
        check({tag, " perf_fetched"}, bus.perf_fetched, 32'h0);
        check({tag, " perf_bubbles"}, bus.perf_bubbles, 32'h0);
`endif
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_addr;
    } vec_t;

    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_0003;
    localparam logic [31:0] W2 = 32'h0109_5020;
    localparam logic [31:0] W3 = 32'hAC0A_0010;
    localparam logic [31:0] WE = 32'hA000_000E;
    localparam logic [31:0] WF = 32'hA000_000F;

    vec_t tbl [21];

    initial begin
        n_checks = 0;
        n_errors = 0;
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
        for (int i = 4; i < int'(N_WORDS); i++) words[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < int'(N_WORDS); i++) begin
            mem_b[4*i]     = words[i][7:0];
            mem_b[4*i + 1] = words[i][15:8];
            mem_b[4*i + 2] = words[i][23:16];
            mem_b[4*i + 3] = words[i][31:24];
        end

        // {stall, redirect_valid, redirect_pc} -> state after the following edge
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, W0,    1'b0, 32'h04};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[3]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, W2,    1'b0, 32'h0C};
        tbl[6]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0, 1'b0, 32'h04};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[9]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0C};
        tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, W3,    1'b0, 32'h10};
        tbl[11] = '{1'b0, 1'b1, 32'h06, 1'b0, 32'h00, 32'h0, 1'b1, 32'h10};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0, 1'b1, 32'h10};
        tbl[13] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0, 1'b0, 32'h00};
        tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, W0,    1'b0, 32'h04};
        tbl[15] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04, W1,    1'b0, 32'h08};
        tbl[16] = '{1'b0, 1'b1, 32'h38, 1'b0, 32'h00, 32'h0, 1'b0, 32'h38};
        tbl[17] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h38, WE,    1'b0, 32'h3C};
        tbl[18] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h3C, WF,    1'b1, 32'h3C};
        tbl[19] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0, 1'b1, 32'h3C};
        tbl[20] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0, 1'b1, 32'h3C};

        // Reset held over two edges, then released between edges.
        reset = 1'b1;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Directed vectors: boot, stall/release, redirect, bad redirect, end of memory.
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].stall, tbl[i].rv, tbl[i].rpc);
            check($sformatf("row%0d if_valid", i), 32'(bus.if_valid), 32'(tbl[i].e_valid));
            check($sformatf("row%0d if_instr", i), bus.if_instr, tbl[i].e_instr);
            check($sformatf("row%0d fault", i), 32'(bus.fault), 32'(tbl[i].e_fault));
            check($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].e_addr);
            if (tbl[i].e_valid) begin
                check($sformatf("row%0d if_pc", i), bus.if_pc, tbl[i].e_pc);
                check($sformatf("row%0d if_pc_plus4", i), bus.if_pc_plus4, tbl[i].e_pc + 32'd4);
            end
        end

        // Recover from fault, stall on word0, then reset asynchronously mid-stall.
        cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("stall_hold if_instr", bus.if_instr, W0);
        check("stall_hold imem_addr", bus.imem_addr, 32'h4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Random stall/redirect traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit          s, rv;
            logic [31:0] rpc;
            int          r;
            s  = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 8);
            r  = int'($urandom_range(0, 9));
            if (r < 7)       rpc = 32'($urandom_range(0, N_WORDS - 1)) << 2;
            else if (r == 7) rpc = 32'($urandom_range(0, IMEM_BYTES - 1)) | 32'h1;
            else if (r == 8) rpc = 32'(IMEM_BYTES);
            else             rpc = $urandom;
            cycle(s, rv, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the byte-addressed, synchronous-read instruction memory. The memory has a 64-byte default depth, assembles a little-endian word, and has 1-cycle read latency.
- Owns the fetch PC and drives the memory address.
- Tags each returned word with its PC.
- Absorbs hazard-unit stalls with a one-entry hold buffer, so no refetch and no bubble on release.
- Applies branch/jump redirects.
- Sits between the PC logic and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
IMEM_BYTES, 64, instruction memory depth in bytes; legal fetch iff addr+3 < IMEM_BYTES

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  IF/ID not accepting; hold current output
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
imem_addr  output  32  address to instruction memory (= fetch_pc)
imem_rdata  input  32  memory data, valid for the address sampled at previous edge
if_valid  output  1  if_instr/if_pc hold a real instruction
if_instr  output  32  fetched instruction; 0 when if_valid=0
if_pc  output  32  PC of if_instr
if_pc_plus4  output  32  if_pc + 4, mod 2^32
fault  output  1  sticky illegal-fetch flag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - fetch_pc=RESET_PC, state=BOOT
  - rsp_valid=0, rsp_pc=0, hold_valid=0, hold_instr=0
  - Outputs: imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fault=0
- Registers: fetch_pc (address being read); rsp_pc/rsp_valid (address whose data is on imem_rdata); hold_instr/hold_valid.
- Output mux:
  - if_valid = rsp_valid | hold_valid.
  - if_instr = hold_valid ? hold_instr : imem_rdata, gated to 0 when !if_valid.
- Priority per edge: reset > redirect > stall > advance.
- States:
  - BOOT: one cycle. Memory reads RESET_PC.
    - Next edge: rsp_pc<=fetch_pc, rsp_valid<=1, fetch_pc+=4, then RUN.
    - Redirect in BOOT is handled as in RUN.
  - RUN:
    - Advance (!stall): rsp_pc<=fetch_pc, rsp_valid<=1, fetch_pc<=fetch_pc+4, hold_valid<=0.
    - If stall && if_valid: hold_instr<=imem_rdata, hold_valid<=1, pointers frozen, then STALL.
    - If stall && !if_valid: pointers frozen, stay RUN.
  - STALL:
    - Output comes from hold_instr. fetch_pc frozen, so memory keeps reading the next word.
    - On stall=0: advance as in RUN, clear hold_valid, then RUN.
    - Zero-bubble release: the word at the new rsp_pc is already on imem_rdata.
  - FAULT:
    - if_valid=0, fault=1, fetch_pc frozen.
    - Exit only by reset or by a legal redirect, which goes to BOOT-like restart: rsp_valid=0 and fault cleared.
- Redirect (any non-FAULT state, overrides stall):
  - fetch_pc<=redirect_pc, rsp_valid<=0, hold_valid<=0, then RUN.
  - Exactly one bubble: if_valid=0 the cycle after the edge, target word valid the next.
- Fault conditions, checked on the value about to be loaded into fetch_pc. Either one loads nothing and enters FAULT:
  - redirect_pc[1:0]!=0
  - addr+3 >= IMEM_BYTES
- Sequential overflow: advancing past IMEM_BYTES-4 faults. No wrap-around.
- Current output on a fault edge: the instruction currently on the output still completes if already valid and not stalled.
- Reset mid-stall or mid-redirect discards everything immediately; outputs go to reset values asynchronously.

Optional Feature:
Macro: IMEM_FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_bubbles[31:0], cleared by reset, saturating at all-ones.
  - perf_fetched counts cycles with if_valid && !stall.
  - perf_bubbles counts cycles with !if_valid outside FAULT.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, RUN, STALL, FAULT}
  - PC_STEP=4, PC_W=32, word-alignment mask
- One sub-module, fetch_hold_buf: hold_instr/hold_valid register plus output mux.
  - Inputs: capture, clear, imem_rdata, rsp_valid.

Test Plan:
Memory preloaded with IM word0=0x20080005, word1=0x20090003, word2=0x01095020, word3=0xAC0A0010.
1. Reset release, no stall -> BOOT 1 cycle.
   - Then if_pc=0x0/0x20080005, 0x4/0x20090003, 0x8/0x01095020 on consecutive cycles.
   - if_pc_plus4 = if_pc+4.
2. stall high 3 cycles while if_pc=0x4 -> if_instr=0x20090003 held all 3 cycles. Cycle after release: if_pc=0x8/0x01095020, no bubble.
3. redirect_valid with redirect_pc=0xC while stalled at 0x4 -> one cycle if_valid=0, then if_pc=0xC/0xAC0A0010.
4. redirect_pc=0x6 -> fault=1 and if_valid=0 next cycle. Then redirect_pc=0x0 -> fault=0, word0 after one bubble.
5. Sequential run from 0x38 with IMEM_BYTES=64 -> 0x38 and 0x3C delivered. Advance to 0x40 sets fault, and 0x40 is never issued valid.
6. Assert reset asynchronously mid-STALL -> outputs zero before next edge, imem_addr=RESET_PC. With IMEM_FETCH_PERF_EN, both counters read 0.
